// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the cpu_mem_model data-memory responder.
package cpu_mem_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/cpu_mem_model_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter
  import cpu_mem_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_mem_model.sv
// Parametrised data-memory responder for the CPU mem_req/mem_ready bus with
// configurable latency, runtime wait states, range checking, backdoor preload and counters.
module cpu_mem_model
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err,
  input  logic [3:0]        extra_wait,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [DATA_W-1:0] bd_wdata,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  // LATENCY (max 15) plus extra_wait (max 15) needs five bits.
  localparam int WC_W = 5;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("cpu_mem_model: LATENCY must be in 0..15");
  end
  if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("cpu_mem_model: DEPTH must be in 1..2**ADDR_W");
  end

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WC_W-1:0]   wc;
  logic [WC_W-1:0]   wc_load;
  logic              addr_ok;
  logic              bd_ok;
  logic              capture;
  logic              commit_wr;

  logic [DATA_W-1:0] mem [DEPTH];

  assign wc_load   = WC_W'(LATENCY) + WC_W'(extra_wait);
  assign addr_ok   = {1'b0, addr_q} < DEPTH_L;
  assign bd_ok     = {1'b0, bd_addr} < DEPTH_L;
  assign capture   = (state == IDLE) && mem_req;
  assign commit_wr = (state == RESP) && we_q && addr_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (mem_req) state_nx = (wc_load == '0) ? RESP : WAIT;
      WAIT: if (wc == WC_W'(1)) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_ready = 1'b0;
    mem_err   = 1'b0;
    mem_rdata = '0;
    busy      = (state != IDLE);
    if (state == RESP) begin
      mem_ready = 1'b1;
      mem_err   = !addr_ok;
      if (addr_ok && !we_q) mem_rdata = mem[addr_q];
    end
  end

  // Request fields are frozen at capture; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wc      <= '0;
    end else if (capture) begin
      addr_q  <= mem_addr;
      we_q    <= mem_we;
      wdata_q <= mem_wdata;
      wc      <= wc_load;
    end else if (state == WAIT) begin
      wc <= wc - 1'b1;
    end
  end

  // NOTE: the storage array has no reset; contents survive rst by design.
  // The CPU commit is written second so it wins a same-address collision with the backdoor.
  always_ff @(posedge clk) begin
    if (bd_we && bd_ok) mem[bd_addr] <= bd_wdata;
    if (commit_wr) mem[addr_q] <= wdata_q;
  end

  sat_counter #(.W(CNT_W)) u_rd_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  ((state == RESP) && addr_ok && !we_q),
    .clr  (1'b0),
    .count(rd_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wr_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (commit_wr),
    .clr  (1'b0),
    .count(wr_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  ((state == RESP) && !addr_ok),
    .clr  (1'b0),
    .count(err_cnt)
  );

endmodule
